// File: rtl/instr_mem_loader.sv
// Program store for the 4-bit core: zeroed after reset, (re)loaded from a valid/ready
// word stream while the core is held in reset, then read combinationally in RUN.
module instr_mem_loader #(
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_load,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    input  logic [3:0]         instruction_addr,
    output logic [INSTR_W-1:0] instruction,
    output logic               cpu_reset_n,
    output logic [4:0]         prog_len,
    output logic               busy
);

    localparam int DEPTH = 16;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t             state;
    logic [3:0]         clr_ptr;
    logic [3:0]         wptr;
    logic [INSTR_W-1:0] mem [DEPTH];
    logic               accept;

    assign accept = (state == LOAD) && load_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= CLEAR;
            clr_ptr     <= 4'd0;
            wptr        <= 4'd0;
            prog_len    <= 5'd0;
            cpu_reset_n <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 4'd1;
                    if (clr_ptr == 4'd15) state <= IDLE;
                end
                IDLE: begin
                    if (start_load) begin
                        state <= LOAD;
                        wptr  <= 4'd0;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        wptr <= wptr + 4'd1;
                        // Entry 15 always ends the load, even without load_last.
                        if (load_last || (wptr == 4'd15)) begin
                            state       <= RUN;
                            prog_len    <= {1'b0, wptr} + 5'd1;
                            cpu_reset_n <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (start_load) begin
                        state       <= LOAD;
                        wptr        <= 4'd0;
                        cpu_reset_n <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Storage carries no reset of its own; the CLEAR walk zeroes it instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == CLEAR) mem[clr_ptr] <= '0;
            else if (accept)    mem[wptr]    <= load_data;
        end
    end

    assign load_ready  = (state == LOAD);
    assign busy        = (state == CLEAR) || (state == LOAD);
    assign instruction = (state == RUN) ? mem[instruction_addr] : '0;

endmodule
